// File: rtl/hsiao2_64_err_mon.sv
// Error monitor behind the 72/64 Hsiao SEC-DED decoder: saturating CE/UE counters, first-UE address capture, irq, scrub requester.
// Define HSIAO2_64_SCRUB_EN to build the scrub FSM; otherwise the scrub outputs are tied low.
module hsiao2_64_err_mon #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [63:0]       i_data,
   input  logic              i_err_detec,
   input  logic              i_err_corr,
   input  logic              i_clr,
   input  logic              i_scrub_ack,
   output logic [CNT_W-1:0]  o_corr_cnt,
   output logic [CNT_W-1:0]  o_fatal_cnt,
   output logic              o_first_vld,
   output logic [ADDR_W-1:0] o_first_addr,
   output logic              o_irq,
   output logic              o_scrub_req,
   output logic [ADDR_W-1:0] o_scrub_addr,
   output logic [63:0]       o_scrub_data,
   output logic              o_scrub_drop
);

   // The decoder's own fatal flag is unusable (it is set on clean words), so UE is derived here.
   logic sample, ce, ue;
   assign sample = enable & i_valid;
   assign ce     = sample & i_err_corr;
   assign ue     = sample & i_err_detec & ~i_err_corr;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_corr_cnt   <= '0;
         o_fatal_cnt  <= '0;
         o_first_vld  <= 1'b0;
         o_first_addr <= '0;
         o_irq        <= 1'b0;
      end else if (i_clr) begin
         o_corr_cnt   <= '0;
         o_fatal_cnt  <= '0;
         o_first_vld  <= 1'b0;
         o_first_addr <= '0;
         o_irq        <= 1'b0;
      end else begin
         if (ce)
            o_corr_cnt <= sat_inc(o_corr_cnt);
         if (ue) begin
            o_fatal_cnt <= sat_inc(o_fatal_cnt);
            o_irq       <= 1'b1;
            if (!o_first_vld) begin
               o_first_vld  <= 1'b1;
               o_first_addr <= i_addr;
            end
         end
      end
   end

`ifdef HSIAO2_64_SCRUB_EN
   typedef enum logic {S_IDLE, S_REQ} scrub_state_t;
   scrub_state_t state, state_nx;
   logic         load, drop_nx;

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      drop_nx  = 1'b0;
      case (state)
         S_IDLE: begin
            if (ce) begin
               load     = 1'b1;
               state_nx = S_REQ;
            end
         end
         S_REQ: begin
            // An ack frees the single entry in the same cycle, so a coincident CE is accepted.
            if (i_scrub_ack) begin
               if (ce) load = 1'b1;
               else    state_nx = S_IDLE;
            end else if (ce) begin
               drop_nx = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         o_scrub_addr <= '0;
         o_scrub_data <= '0;
         o_scrub_drop <= 1'b0;
      end else begin
         state        <= state_nx;
         o_scrub_drop <= drop_nx;
         if (load) begin
            o_scrub_addr <= i_addr;
            o_scrub_data <= i_data;
         end
      end
   end

   assign o_scrub_req = (state == S_REQ);
`else
   logic unused_scrub;
   assign unused_scrub = i_scrub_ack ^ (^i_data);
   assign o_scrub_req  = 1'b0;
   assign o_scrub_addr = '0;
   assign o_scrub_data = '0;
   assign o_scrub_drop = 1'b0;
`endif

endmodule

// File: doc/hsiao2_64_err_mon.md
# hsiao2_64_err_mon

Error monitor and scrub requester that sits directly downstream of the 72/64 Hsiao SEC-DED decoder. It consumes the decoder's registered outputs plus an address tag aligned to them. It keeps saturating corrected/uncorrectable event counters and captures the address of the first uncorrectable word. It issues a single-entry req/ack scrub request carrying the corrected data back to the memory write path.

## Interface
Parameters:
- ADDR_W, 32, width of address tag
- CNT_W, 16, width of each event counter

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  event-sampling qualifier, same meaning as on the decoder
- i_valid  in  1  decoder output valid
- i_addr  in  ADDR_W  address of the word presented on i_data
- i_data  in  64  decoder corrected data
- i_err_detec  in  1  decoder: nonzero syndrome
- i_err_corr  in  1  decoder: single-bit error corrected
- i_clr  in  1  synchronous clear of counters, capture and irq
- i_scrub_ack  in  1  scrub write accepted
- o_corr_cnt  out  CNT_W  corrected-event count, saturating
- o_fatal_cnt  out  CNT_W  uncorrectable-event count, saturating
- o_first_vld  out  1  o_first_addr holds a captured address
- o_first_addr  out  ADDR_W  address of first uncorrectable word since reset/clear
- o_irq  out  1  level, set on any uncorrectable event
- o_scrub_req  out  1  scrub request pending
- o_scrub_addr  out  ADDR_W  scrub target address
- o_scrub_data  out  64  corrected data to write back
- o_scrub_drop  out  1  one-cycle pulse: corrected event not queued, FSM busy

## Operation
- Sample = enable & i_valid at rising edge. Corrected event (CE) = sample & i_err_corr. Uncorrectable event (UE) = sample & i_err_detec & ~i_err_corr. The decoder's fatal flag is not used; it also asserts on clean words.
- CE: o_corr_cnt += 1. UE: o_fatal_cnt += 1, o_irq <= 1. Both counters hold at all-ones; no wrap.
- First UE with o_first_vld=0 loads o_first_addr and sets o_first_vld. Later UEs leave the capture unchanged.
- i_clr has priority over same-cycle events for the counters, the capture and irq: all go to 0 and the event is not counted. i_clr does not affect the scrub FSM.
- Scrub FSM states:
  - IDLE: on CE, load addr/data and go to REQ.
  - REQ: hold o_scrub_req and the payload stable until i_scrub_ack is sampled high, then return to IDLE.
  - CE in the same cycle as ack: reload the payload and stay in REQ, so back-to-back requests are accepted.
  - CE in REQ without ack: payload unchanged, o_scrub_drop pulses one cycle.
- The handshake progresses regardless of enable. i_scrub_ack in IDLE is ignored.
- UE never generates a scrub request.

## Timing
- All outputs registered. Reset values: counters 0, o_first_vld 0, o_first_addr 0, o_irq 0, o_scrub_req 0, o_scrub_addr 0, o_scrub_data 0, o_scrub_drop 0. FSM resets to IDLE.
- Latency from sampling edge: counters, capture, irq, o_scrub_req and o_scrub_drop are all visible after 1 cycle.
- o_scrub_req deasserts the cycle after ack is sampled, unless it is reloaded.
- Reset mid-request drops the pending scrub, with no ack expected.

## Configuration
- HSIAO2_64_SCRUB_EN defined: scrub FSM and payload registers are built as above.
- Not defined: all ports remain. o_scrub_req, o_scrub_addr, o_scrub_data and o_scrub_drop are tied 0, and i_scrub_ack is ignored. Counters, capture and irq are unchanged.

## Test plan
- Reset, then 3 CE samples at addr 0x10/0x14/0x18 with ack held 1 -> o_corr_cnt=3 and 3 scrub requests. Last request shows addr 0x18 and data equal to i_data; o_irq=0.
- UE at 0x40 then UE at 0x80 -> o_fatal_cnt=2, o_first_addr=0x40, o_first_vld=1, o_irq=1, no scrub request.
- CE at 0x100 with ack held 0, then CE at 0x200 -> o_scrub_drop pulses once and o_scrub_addr stays 0x100. Ack -> req drops next cycle.
- CNT_W=4: 17 CE -> o_corr_cnt=15. Then i_clr coincident with a UE -> o_fatal_cnt=0, o_irq=0, o_first_vld=0.
- enable=0 with i_valid=1 and i_err_corr=1 -> no count, no request. reset_n low while o_scrub_req=1 -> all outputs 0 asynchronously.
- Build without HSIAO2_64_SCRUB_EN: CE stream -> o_scrub_req stays 0 and counters still increment.
